// File: rtl/keynsham_timer_defs.sv
// Shared register map and CONTROL field layout for the keynsham multi-channel timer.
package keynsham_timer_defs;

  // Channel bank word offsets
  localparam logic [1:0] RegCount    = 2'd0;
  localparam logic [1:0] RegReload   = 2'd1;
  localparam logic [1:0] RegControl  = 2'd2;
  localparam logic [1:0] RegEoi      = 2'd3;

  // Global bank word offsets
  localparam logic [1:0] RegPending  = 2'd0;
  localparam logic [1:0] RegClear    = 2'd1;
  localparam logic [1:0] RegEnable   = 2'd2;
  localparam logic [1:0] RegReserved = 2'd3;

  // CONTROL bit positions
  localparam int unsigned CtrlPeriodicBit = 0;
  localparam int unsigned CtrlEnableBit   = 1;
  localparam int unsigned CtrlIrqEnBit    = 2;
  localparam int unsigned PrescaleLsb     = 8;

endpackage

// File: rtl/keynsham_timer_channel.sv
// One timer channel: prescaler, down-counter, control fields and latched pending flag.
module keynsham_timer_channel #(
  parameter int unsigned Width     = 32,
  parameter int unsigned PrescaleW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_count_i,
  input  logic                 wr_reload_i,
  input  logic                 wr_control_i,
  input  logic                 clr_pending_i,   // EOI or global CLEAR bit
  input  logic                 wr_enable_i,     // global ENABLE alias write
  input  logic [Width-1:0]     wr_value_i,
  input  logic                 wr_periodic_i,
  input  logic                 wr_enable_val_i,
  input  logic                 wr_irq_en_i,
  input  logic [PrescaleW-1:0] wr_prescale_i,
  output logic [Width-1:0]     count_o,
  output logic [Width-1:0]     reload_o,
  output logic                 periodic_o,
  output logic                 enable_o,
  output logic                 irq_en_o,
  output logic [PrescaleW-1:0] prescale_o,
  output logic                 pending_o
);

  logic [Width-1:0]     count_q, count_d, reload_q, reload_d;
  logic [PrescaleW-1:0] pcnt_q, pcnt_d, prescale_q, prescale_d;
  logic                 periodic_q, periodic_d, enable_q, enable_d;
  logic                 irq_en_q, irq_en_d, pending_q, pending_d;
  logic                 tick, expire, en_wr;

  // Next-state: bus writes take priority over ticks, expiry over pending clears
  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    pcnt_d     = pcnt_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;

    tick   = enable_q && (pcnt_q == prescale_q);
    // A COUNT/RELOAD write swallows the tick, so it cannot expire either
    expire = tick && (count_q == Width'(1)) && !wr_count_i && !wr_reload_i;
    en_wr  = wr_control_i || wr_enable_i;

    if (enable_q) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    if (wr_count_i) begin
      count_d = wr_value_i;
    end else if (wr_reload_i) begin
      count_d  = wr_value_i;
      reload_d = wr_value_i;
    end else if (tick) begin
      if (count_q > Width'(1)) begin
        count_d = count_q - 1'b1;
      end else if (count_q == Width'(1)) begin
        count_d = periodic_q ? reload_q : '0;
      end else if (periodic_q) begin
        count_d = reload_q;
      end
    end

    if (en_wr) begin
      enable_d = wr_enable_val_i;
      if (wr_enable_val_i && !enable_q) begin
        pcnt_d = '0;
      end
    end else if (expire && !periodic_q) begin
      enable_d = 1'b0;
    end

    if (wr_control_i) begin
      periodic_d = wr_periodic_i;
      irq_en_d   = wr_irq_en_i;
      prescale_d = wr_prescale_i;
    end

    if (expire) begin
      pending_d = 1'b1;
    end else if (clr_pending_i) begin
      pending_d = 1'b0;
    end
  end

  // Channel state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= '1;
      reload_q   <= '1;
      pcnt_q     <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
    end
  end

  assign count_o    = count_q;
  assign reload_o   = reload_q;
  assign periodic_o = periodic_q;
  assign enable_o   = enable_q;
  assign irq_en_o   = irq_en_q;
  assign prescale_o = prescale_q;
  assign pending_o  = pending_q;

endmodule

// File: rtl/keynsham_multitimer.sv
// Multi-channel timer: bus decode, global status/clear/enable bank, read mux and interrupts.
module keynsham_multitimer
  import keynsham_timer_defs::*;
#(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                bus_access,
  input  logic                                timer_cs,
  input  logic [$clog2(NUM_TIMERS+1)+1:0]     reg_sel,
  input  logic [31:0]                         bus_wr_val,
  input  logic                                bus_wr_en,
  input  logic [3:0]                          bus_bytesel,
  output logic                                bus_error,
  output logic                                bus_ack,
  output logic [31:0]                         bus_data,
  output logic [NUM_TIMERS-1:0]               irq_out,
  output logic                                irq_any
);

  localparam int unsigned     BankW      = $clog2(NUM_TIMERS + 1);
  localparam logic [BankW-1:0] GlobalBank = BankW'(NUM_TIMERS);

  logic [BankW-1:0]      bank;
  logic [1:0]            word;
  logic                  access, bad, wr, glb_wr;
  logic [31:0]           rdata;
  logic                  ack_q, err_q;
  logic [31:0]           data_q;

  logic [WIDTH-1:0]      count    [NUM_TIMERS];
  logic [WIDTH-1:0]      reload   [NUM_TIMERS];
  logic [PRESCALE_W-1:0] prescale [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] periodic, enable, irq_en, pending;

  // Byte enables are ignored (full-word only); write data is sliced per field
  logic unused_bus;
  assign unused_bus = ^{bus_bytesel, bus_wr_val};

  assign bank   = reg_sel[BankW+1:2];
  assign word   = reg_sel[1:0];
  assign access = bus_access && timer_cs;
  assign bad    = (bank > GlobalBank) || ((bank == GlobalBank) && (word == RegReserved));
  assign wr     = access && bus_wr_en && !bad;
  assign glb_wr = wr && (bank == GlobalBank);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr && (bank == BankW'(i));

    keynsham_timer_channel #(
      .Width     (WIDTH),
      .PrescaleW (PRESCALE_W)
    ) u_ch (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .wr_count_i      (ch_wr && (word == RegCount)),
      .wr_reload_i     (ch_wr && (word == RegReload)),
      .wr_control_i    (ch_wr && (word == RegControl)),
      .clr_pending_i   ((ch_wr && (word == RegEoi)) ||
                        (glb_wr && (word == RegClear) && bus_wr_val[i])),
      .wr_enable_i     (glb_wr && (word == RegEnable)),
      .wr_value_i      (bus_wr_val[WIDTH-1:0]),
      .wr_periodic_i   (bus_wr_val[CtrlPeriodicBit]),
      .wr_enable_val_i (ch_wr ? bus_wr_val[CtrlEnableBit] : bus_wr_val[i]),
      .wr_irq_en_i     (bus_wr_val[CtrlIrqEnBit]),
      .wr_prescale_i   (bus_wr_val[PrescaleLsb +: PRESCALE_W]),
      .count_o         (count[i]),
      .reload_o        (reload[i]),
      .periodic_o      (periodic[i]),
      .enable_o        (enable[i]),
      .irq_en_o        (irq_en[i]),
      .prescale_o      (prescale[i]),
      .pending_o       (pending[i])
    );
  end

  // Read mux over channel banks and the global bank; unused bits read 0
  always_comb begin
    rdata = '0;
    if (bank == GlobalBank) begin
      case (word)
        RegPending: rdata[NUM_TIMERS-1:0] = pending;
        RegEnable:  rdata[NUM_TIMERS-1:0] = enable;
        default:    rdata = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (bank == BankW'(i)) begin
          case (word)
            RegCount:  rdata[WIDTH-1:0] = count[i];
            RegReload: rdata[WIDTH-1:0] = reload[i];
            RegControl: begin
              rdata[CtrlPeriodicBit]            = periodic[i];
              rdata[CtrlEnableBit]              = enable[i];
              rdata[CtrlIrqEnBit]               = irq_en[i];
              rdata[PrescaleLsb +: PRESCALE_W]  = prescale[i];
            end
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  // Registered bus response, one ack per access cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= access;
      err_q  <= access && bad;
      data_q <= (access && !bad) ? rdata : '0;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_error = err_q;
  assign bus_data  = data_q;
  assign irq_out   = pending & irq_en;
  assign irq_any   = |irq_out;

endmodule

// File: tb/tb_keynsham_multitimer.sv
// Self-checking bench: directed scenarios plus random bus traffic against a behavioural model.
module tb_keynsham_multitimer;

  localparam int NT  = 4;
  localparam int W   = 32;
  localparam int PW  = 8;
  localparam int RSW = $clog2(NT + 1) + 2;
  localparam logic [63:0] WMASK = (64'd1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           bus_access = 1'b0;
  logic           timer_cs = 1'b0;
  logic [RSW-1:0] reg_sel = '0;
  logic [31:0]    bus_wr_val = '0;
  logic           bus_wr_en = 1'b0;
  logic [3:0]     bus_bytesel = 4'hf;
  logic           bus_error, bus_ack, irq_any;
  logic [31:0]    bus_data;
  logic [NT-1:0]  irq_out;

  always #5 clk = ~clk;

  keynsham_multitimer #(
    .NUM_TIMERS (NT),
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_access  (bus_access),
    .timer_cs    (timer_cs),
    .reg_sel     (reg_sel),
    .bus_wr_val  (bus_wr_val),
    .bus_wr_en   (bus_wr_en),
    .bus_bytesel (bus_bytesel),
    .bus_error   (bus_error),
    .bus_ack     (bus_ack),
    .bus_data    (bus_data),
    .irq_out     (irq_out),
    .irq_any     (irq_any)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  longint      cyc = 0;
  logic [31:0] last_data;
  logic        last_err;
  bit          drive_cs = 1'b1;

  // Behavioural model of each channel
  logic [63:0] m_count [NT];
  logic [63:0] m_reload[NT];
  int          m_pcnt  [NT];
  int          m_ps    [NT];
  bit          m_per   [NT];
  bit          m_en    [NT];
  bit          m_ie    [NT];
  bit          m_pend  [NT];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_count[i] = WMASK; m_reload[i] = WMASK; m_pcnt[i] = 0; m_ps[i] = 0;
      m_per[i] = 0; m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input int bank, input int wd);
    logic [31:0] r = '0;
    if (bank < NT) begin
      case (wd)
        0: r = m_count[bank][31:0];
        1: r = m_reload[bank][31:0];
        2: r = 32'(m_per[bank]) | (32'(m_en[bank]) << 1) | (32'(m_ie[bank]) << 2) |
               (32'(m_ps[bank]) << 8);
        default: r = '0;
      endcase
    end else if (bank == NT) begin
      for (int i = 0; i < NT; i++) begin
        if (wd == 0) r[i] = m_pend[i];
        if (wd == 2) r[i] = m_en[i];
      end
    end
    return r;
  endfunction

  function automatic logic [NT-1:0] model_irq();
    logic [NT-1:0] v;
    for (int i = 0; i < NT; i++) v[i] = m_pend[i] & m_ie[i];
    return v;
  endfunction

  // Advance one clock: predict from the currently driven inputs, then compare
  task automatic step();
    bit          acc = bus_access && timer_cs;
    int          bank = int'(reg_sel >> 2);
    int          wd = int'(reg_sel[1:0]);
    bit          bad = (bank > NT) || (bank == NT && wd == 3);
    bit          wr = acc && bus_wr_en && !bad;
    bit          gw = wr && (bank == NT);
    logic [31:0] d = bus_wr_val;
    logic [31:0] exp_data = (acc && !bad) ? model_read(bank, wd) : 32'h0;
    logic [NT-1:0] exp_irq;
    for (int i = 0; i < NT; i++) begin
      bit cw     = wr && (bank == i);
      bit tick   = m_en[i] && (m_pcnt[i] == m_ps[i]);
      bit ld     = cw && (wd == 0 || wd == 1);
      bit expire = tick && (m_count[i] == 1) && !ld;
      bit en_w   = (cw && wd == 2) || (gw && wd == 2);
      bit en_v   = (cw && wd == 2) ? d[1] : d[i];
      if (m_en[i]) m_pcnt[i] = tick ? 0 : (m_pcnt[i] + 1) % (1 << PW);
      if (ld) begin
        m_count[i] = 64'(d) & WMASK;
        if (wd == 1) m_reload[i] = 64'(d) & WMASK;
      end else if (tick) begin
        if (m_count[i] > 1) m_count[i] = m_count[i] - 1;
        else if (m_count[i] == 1) m_count[i] = m_per[i] ? m_reload[i] : 64'd0;
        else if (m_per[i]) m_count[i] = m_reload[i];
      end
      if (en_w) begin
        if (en_v && !m_en[i]) m_pcnt[i] = 0;
        m_en[i] = en_v;
      end else if (expire && !m_per[i]) begin
        m_en[i] = 0;
      end
      if (cw && wd == 2) begin
        m_per[i] = d[0]; m_ie[i] = d[2]; m_ps[i] = int'((d >> 8) & ((1 << PW) - 1));
      end
      if (expire) m_pend[i] = 1;
      else if ((cw && wd == 3) || (gw && wd == 1 && d[i])) m_pend[i] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_irq = model_irq();
    check_eq("ack", bus_ack, acc);
    if (acc) begin
      check_eq("bus_error", bus_error, bad);
      check_eq("bus_data", bus_data, exp_data);
    end
    check_eq("irq_out", irq_out, exp_irq);
    check_eq("irq_any", irq_any, |exp_irq);
  endtask

  task automatic bus(input bit wr, input int bank, input int wd, input logic [31:0] data);
    bus_access = 1'b1; timer_cs = drive_cs; bus_wr_en = wr;
    reg_sel = RSW'(bank * 4 + wd); bus_wr_val = data;
    step();
    last_data = bus_data; last_err = bus_error;
    bus_access = 1'b0; timer_cs = 1'b0; bus_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_irq(input logic [NT-1:0] mask, input int bound, output int n);
    n = 0;
    while (((irq_out & mask) == '0) && (n < bound)) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus_access = 1'b0; timer_cs = 1'b0; bus_wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check_eq("rst_irq_out", irq_out, '0);
    check_eq("rst_irq_any", irq_any, 0);
    check_eq("rst_ack", bus_ack, 0);
    check_eq("rst_data", bus_data, 0);
    check_eq("rst_error", bus_error, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    longint t1, t2;
    do_reset();

    // Reset values through the bus
    bus(0, 0, 0, 0);
    check_eq("rst_count", last_data, 32'hffff_ffff);
    check_eq("rst_count_err", last_err, 0);

    // One-shot on ch1
    bus(1, 1, 1, 5);
    bus(1, 1, 2, 32'h006);
    wait_irq(4'b0010, 20, n);
    check_eq("oneshot_latency", n, 5);
    bus(0, 1, 0, 0);
    check_eq("oneshot_count", last_data, 0);
    bus(0, 1, 2, 0);
    check_eq("oneshot_control", last_data, 32'h004);
    bus(1, 1, 3, 0);
    check_eq("eoi_drop", irq_out[1], 0);

    // Periodic with prescaler on ch0
    bus(1, 0, 1, 3);
    bus(1, 0, 2, 32'h207);
    wait_irq(4'b0001, 40, n);
    t1 = cyc;
    bus(0, NT, 0, 0);
    check_eq("global_pending", last_data, 32'h1);
    bus(1, NT, 1, 32'h1);
    check_eq("clear_pending", irq_out[0], 0);
    wait_irq(4'b0001, 40, n);
    t2 = cyc;
    check_eq("periodic_interval", t2 - t1, 9);
    bus(1, 0, 2, 0);
    bus(1, NT, 1, 32'h1);

    // EOI collides with expiry: pending must survive
    bus(1, 0, 1, 3);
    bus(1, 0, 2, 32'h007);
    wait_irq(4'b0001, 20, n);
    step();
    step();
    bus(1, 0, 3, 0);
    check_eq("eoi_collision", irq_out[0], 1);
    // RELOAD write on a tick cycle wins
    bus(1, 0, 1, 32'h77);
    bus(0, 0, 0, 0);
    check_eq("reload_collision", last_data, 32'h77);
    bus(1, 0, 2, 0);
    bus(1, 0, 3, 0);

    // irq_enable masks the output but pending still latches
    bus(1, 2, 1, 1);
    bus(1, 2, 2, 32'h002);
    idle(3);
    check_eq("irq_masked", irq_out[2], 0);
    bus(0, NT, 0, 0);
    check_eq("masked_pending", last_data, 32'h4);
    bus(1, NT, 1, 32'h4);

    // Global ENABLE starts every channel together
    for (int i = 0; i < NT; i++) begin
      bus(1, i, 1, 4);
      bus(1, i, 2, 32'h004);
    end
    bus(1, NT, 2, 32'hF);
    wait_irq(4'hF, 20, n);
    check_eq("enable_sync_irq", irq_out, 4'hF);
    check_eq("enable_sync_latency", n, 4);
    bus(0, NT, 2, 0);
    check_eq("enable_autodisable", last_data, 0);
    bus(1, NT, 1, 32'hF);
    check_eq("clear_all", irq_out, 0);

    // Error responses
    bus(0, NT, 3, 0);
    check_eq("reserved_err", last_err, 1);
    check_eq("reserved_data", last_data, 0);
    bus(1, NT, 3, 32'hF);
    bus(0, NT, 2, 0);
    check_eq("reserved_wr_noeffect", last_data, 0);
    bus(0, 7, 0, 0);
    check_eq("bad_bank_err", last_err, 1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int r = $urandom_range(0, 9);
      int bank = (r < 8) ? (r % (NT + 1)) : $urandom_range(NT + 1, 7);
      int wd = $urandom_range(0, 3);
      logic [31:0] data;
      if (k == 200) do_reset();
      if (bank < NT && wd < 2) data = $urandom_range(0, 12);
      else if (bank < NT && wd == 2) data = ($urandom_range(0, 3) << 8) | $urandom_range(0, 7);
      else data = $urandom_range(0, 15);
      drive_cs = ($urandom_range(0, 7) != 0);
      bus($urandom_range(0, 1) == 1, bank, wd, data);
      drive_cs = 1'b1;
      idle($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keynsham_multitimer.md
Name: keynsham_multitimer

Overview:
- Parametrised successor to the single-channel keynsham timer.
- Provides NUM_TIMERS independent down-counters, each with WIDTH-bit count/reload, a per-channel prescaler, one-shot/periodic mode, one-shot auto-disable and a latched interrupt.
- Adds a global status/clear register bank and a combined interrupt output.
- Sits on the keynsham peripheral bus beside the other memory-mapped peripherals and feeds the interrupt controller.

Parameters:
- NUM_TIMERS, 4: number of channels, 1..8.
- WIDTH, 32: count/reload width, 8..32.
- PRESCALE_W, 8: prescaler divide field width, 1..16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- bus_access  in  1  bus cycle valid
- timer_cs  in  1  block select
- reg_sel  in  clog2(NUM_TIMERS+1)+2  word select; [top:2]=bank (channel index, or NUM_TIMERS = global bank), [1:0]=register
- bus_wr_val  in  32  write data
- bus_wr_en  in  1  write strobe
- bus_bytesel  in  4  byte enables; unused, full-word only
- bus_error  out  1  registered error, valid with bus_ack
- bus_ack  out  1  registered acknowledge
- bus_data  out  32  registered read data, valid with bus_ack
- irq_out  out  NUM_TIMERS  per-channel irq = pending & irq_enable
- irq_any  out  1  OR of irq_out

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low.
- Reset values (rst_n=0 sampled at clk edge): count = reload = all ones; control = 0; prescale counter = 0; pending = 0; bus_ack = bus_error = 0; bus_data = 0; irq_out = 0; irq_any = 0. Reset mid-count discards all state on that edge.
- Channel register map, word offsets:
  - 0 COUNT: RW; a write loads count only.
  - 1 RELOAD: RW; a write loads both reload and count.
  - 2 CONTROL: RW; bit0 periodic, bit1 enable, bit2 irq_enable, [8+PRESCALE_W-1:8] prescale.
  - 3 EOI: write-only, clears pending; reads 0.
- Unused upper bits read 0. Values wider than WIDTH are truncated on write.
- Global bank (index NUM_TIMERS):
  - 0 PENDING: RO; pending vector.
  - 1 CLEAR: write-1-to-clear pending bits; reads 0.
  - 2 ENABLE: RW alias of all enable bits; a write sets every channel's enable at once.
  - 3: reserved.
- Bus timing: bus_ack asserts the cycle after a cycle with bus_access & timer_cs, and lasts one cycle per access cycle. bus_data and bus_error are registered on the same edge.
- bus_error=1: access to global reg 3, or to a bank index > NUM_TIMERS. Writes to these have no effect and read data is 0.
- Prescaler: while enable=1, pcnt increments each clk. When pcnt==prescale, a tick is issued and pcnt returns to 0. prescale=0 gives a tick every clk.
- A 0->1 write of enable clears pcnt. With enable=0, pcnt and count hold.
- On a tick:
  - count>1: count <= count-1.
  - count==1: pending <= 1. Periodic: count <= reload. One-shot: count <= 0 and enable <= 0.
  - count==0: periodic -> count <= reload, no irq. One-shot -> hold.
- Periodic period = (reload)*(prescale+1) clk. reload=0 in periodic produces no irq.
- Simultaneous events:
  - A bus write to COUNT/RELOAD wins over a tick in the same cycle.
  - An expiry setting pending wins over an EOI/CLEAR in the same cycle.
  - A CONTROL write enable=1 wins over one-shot auto-disable in the same cycle.
- irq_out is combinational from pending & irq_enable. Clearing irq_enable masks the output without clearing pending.

Decomposition:
- Shared package/header keynsham_timer_defs: register offset constants (COUNT/RELOAD/CONTROL/EOI = 0..3, PENDING/CLEAR/ENABLE = 0..2), CONTROL bit positions, prescale field LSB (8).
- Sub-module keynsham_timer_channel (one per channel, generate loop): prescaler, counter, pending, control. It takes decoded write strobes and exposes count, reload, control, pending.
- Top level: address decode, global bank, read mux, ack/error registers.

Test Plan:
- Reset: assert rst_n=0 then release; read ch0 COUNT -> ack after 1 cycle, data 0xffffffff, error 0; irq_out = 0.
- One-shot: ch1 RELOAD=5, CONTROL=0x006 (enable, irq_en, prescale 0).
  - irq_out[1]=1 exactly 5 clk after the write.
  - COUNT reads 0 and CONTROL reads 0x004.
  - EOI write drops irq_out[1] the next cycle.
- Periodic with prescaler: ch0 RELOAD=3, CONTROL=0x207 (prescale 2).
  - pending set every 9 clk.
  - Global PENDING reads 0x1.
  - CLEAR write 0x1 clears it.
  - irq_any tracks irq_out.
- Collision: EOI written in the same cycle ch0 expires -> pending remains 1. RELOAD write on a tick cycle -> COUNT reads the written value.
- Global ENABLE: write 0xF with NUM_TIMERS=4 -> all channels start the same cycle. Equal reloads give irq_out 0xF simultaneously.
- Errors: read global reg 3 -> bus_error=1, data 0. Write to global reg 3 -> no state change.
